// File: rtl/kbd_pkg.sv
// Shared constants and types for the port #FE keyboard reader.
// KBD_JOY_EN appends an 8-bit Kempston byte to each SPI frame.
package kbd_pkg;

  localparam int unsigned KEY_ROWS = 8;
  localparam int unsigned KEY_COLS = 5;
  localparam int unsigned KEY_BITS = KEY_ROWS * KEY_COLS;
  localparam int unsigned JOY_BITS = 8;
  localparam int unsigned JOY_KEYS = 5;

  localparam logic       PORT_FE_A0 = 1'b0;
  localparam logic [7:0] PORT_1F    = 8'h1F;
  localparam logic [7:0] IDLE_RD    = 8'hFF;

`ifdef KBD_JOY_EN
  localparam int unsigned FRAME_LEN = KEY_BITS + JOY_BITS;
`else
  localparam int unsigned FRAME_LEN = KEY_BITS;
`endif

  // Next value of the CPU read-data register
  typedef struct packed {
    logic       oe;
    logic [7:0] data;
  } rd_resp_t;

endpackage

// File: rtl/kbd_spi_shift.sv
// SPI receive path: input synchronisers, edge detection, shift register,
// bit counter and frame length check. KBD_JOY_EN adds the joystick output.
module kbd_spi_shift
  import kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEN         = FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kbd_clk,
  input  logic                kbd_cs,
  input  logic                kbd_di,
  input  logic                tape_in,
  output logic                tape_s,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [KEY_BITS-1:0] frame_keys
`ifdef KBD_JOY_EN
  ,
  output logic [JOY_KEYS-1:0] frame_joy
`endif
);

  localparam int unsigned CNT_W = $clog2(LEN + 2);
  localparam int unsigned NEW   = SYNC_STAGES - 2;
  localparam int unsigned OLD   = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, di_sync, tape_sync;
  logic [LEN-1:0]         shadow;
  logic [CNT_W-1:0]       bitcnt;
  logic                   in_frame;
  logic                   clk_rise_c, cs_fall_c, cs_rise_c;

  // CS sync resets low so a frame already running at reset release is never
  // mistaken for a new frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      cs_sync   <= '0;
      di_sync   <= '0;
      tape_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], kbd_cs};
      di_sync   <= {di_sync[SYNC_STAGES-2:0], kbd_di};
      tape_sync <= {tape_sync[SYNC_STAGES-2:0], tape_in};
    end
  end

  assign clk_rise_c = clk_sync[NEW] & ~clk_sync[OLD];
  assign cs_fall_c  = ~cs_sync[NEW] & cs_sync[OLD];
  assign cs_rise_c  = cs_sync[NEW] & ~cs_sync[OLD];

  // Only frames opened by a seen CS fall are shifted and length-checked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      bitcnt    <= '0;
      in_frame  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall_c) begin
        in_frame <= 1'b1;
        bitcnt   <= '0;
      end else if (cs_rise_c) begin
        in_frame <= 1'b0;
        if (in_frame) begin
          frame_ok  <= (bitcnt == CNT_W'(LEN));
          frame_err <= (bitcnt != CNT_W'(LEN));
        end
      end else if (clk_rise_c && in_frame) begin
        shadow <= {shadow[LEN-2:0], di_sync[NEW]};
        if (bitcnt != CNT_W'(LEN + 1))
          bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

  assign tape_s     = tape_sync[OLD];
  assign frame_keys = shadow[LEN-1 -: KEY_BITS];
`ifdef KBD_JOY_EN
  assign frame_joy  = shadow[JOY_KEYS-1:0];
`endif

endmodule

// File: rtl/kbd_spi_port_fe.sv
// Reader side of port #FE: holds the committed key matrix and answers Z80 IN cycles.
// KBD_JOY_EN adds a Kempston joystick answered on port #1F.
module kbd_spi_port_fe
  import kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK_14MHZ,
  input  logic        CPU_RESET,
  input  logic        KBD_CLK,
  input  logic        KBD_CS,
  input  logic        KBD_DI,
  input  logic        CPU_IORQ,
  input  logic        CPU_RD,
  input  logic        CPU_M1,
  input  logic [15:0] A,
  input  logic        TAPE_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        KEYS_VALID,
  output logic        FRAME_ERR
);

  logic                tape_s, frame_ok;
  logic [KEY_BITS-1:0] frame_keys, pend_keys, matrix;
  logic                pend_v;
  logic                rd_fe_c, rd_1f_c;
  logic [KEY_COLS-1:0] row_or_c, keys_c;
  rd_resp_t            resp_c;

`ifdef KBD_JOY_EN
  logic [JOY_KEYS-1:0] frame_joy, pend_joy, joy;
`endif

  kbd_spi_shift #(
    .SYNC_STAGES (SYNC_STAGES),
    .LEN         (FRAME_LEN)
  ) u_shift (
    .clk        (CLK_14MHZ),
    .rst_n      (CPU_RESET),
    .kbd_clk    (KBD_CLK),
    .kbd_cs     (KBD_CS),
    .kbd_di     (KBD_DI),
    .tape_in    (TAPE_IN),
    .tape_s     (tape_s),
    .frame_ok   (frame_ok),
    .frame_err  (FRAME_ERR),
    .frame_keys (frame_keys)
`ifdef KBD_JOY_EN
    ,
    .frame_joy  (frame_joy)
`endif
  );

  assign rd_fe_c = !CPU_IORQ && !CPU_RD && CPU_M1 && (A[0] == PORT_FE_A0);
`ifdef KBD_JOY_EN
  assign rd_1f_c = !CPU_IORQ && !CPU_RD && CPU_M1 && (A[7:0] == PORT_1F);
`else
  logic unused_addr;
  assign rd_1f_c     = 1'b0;
  assign unused_addr = ^A[7:1];
`endif

  // A zero in A[8+r] selects row r; any pressed key in a selected row pulls its column low
  always_comb begin
    row_or_c = '0;
    for (int r = 0; r < KEY_ROWS; r++) begin
      if (!A[8+r])
        row_or_c = row_or_c | matrix[r*KEY_COLS +: KEY_COLS];
    end
    keys_c = ~row_or_c;
  end

  always_comb begin
    resp_c.oe   = 1'b0;
    resp_c.data = IDLE_RD;
    if (rd_fe_c) begin
      resp_c.oe   = 1'b1;
      resp_c.data = {1'b1, tape_s, 1'b1, keys_c};
    end else if (rd_1f_c) begin
      resp_c.oe   = 1'b1;
`ifdef KBD_JOY_EN
      resp_c.data = {3'b000, joy};
`else
      resp_c.data = IDLE_RD;
`endif
    end
  end

  // Good frames wait in pend_* until no #FE read is in progress; a newer frame replaces them
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      matrix     <= '0;
      pend_keys  <= '0;
      pend_v     <= 1'b0;
      KEYS_VALID <= 1'b0;
      D_OUT      <= IDLE_RD;
      D_OE       <= 1'b0;
`ifdef KBD_JOY_EN
      pend_joy   <= '0;
      joy        <= '0;
`endif
    end else begin
      D_OUT <= resp_c.data;
      D_OE  <= resp_c.oe;
      if (frame_ok) begin
        pend_keys <= frame_keys;
        pend_v    <= 1'b1;
`ifdef KBD_JOY_EN
        pend_joy  <= frame_joy;
`endif
      end else if (pend_v && !rd_fe_c) begin
        matrix     <= pend_keys;
        pend_v     <= 1'b0;
        KEYS_VALID <= 1'b1;
`ifdef KBD_JOY_EN
        joy        <= pend_joy;
`endif
      end
    end
  end

endmodule

// File: tb/tb_kbd_spi_port_fe.sv
// Directed bench for kbd_spi_port_fe: SPI frames, IN decode table and frame corner cases.
// Follows KBD_JOY_EN to pick the frame length and port #1F expectations.
module tb_kbd_spi_port_fe;

`ifdef KBD_JOY_EN
  localparam int FLEN = 48;
  localparam bit JOY  = 1'b1;
`else
  localparam int FLEN = 40;
  localparam bit JOY  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, kclk, kcs, kdi, iorq, rd, m1, tape;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        doe, kvalid, ferr;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic err_prev = 1'b0;
  bit   err_long = 1'b0;

  always #5 clk = ~clk;

  kbd_spi_port_fe dut (
    .CLK_14MHZ  (clk),
    .CPU_RESET  (rst_n),
    .KBD_CLK    (kclk),
    .KBD_CS     (kcs),
    .KBD_DI     (kdi),
    .CPU_IORQ   (iorq),
    .CPU_RD     (rd),
    .CPU_M1     (m1),
    .A          (addr),
    .TAPE_IN    (tape),
    .D_OUT      (dout),
    .D_OE       (doe),
    .KEYS_VALID (kvalid),
    .FRAME_ERR  (ferr)
  );

  // Count FRAME_ERR pulses and flag any pulse longer than one clock
  always @(posedge clk) begin
    err_prev <= ferr;
    if (ferr === 1'b1) err_cnt <= err_cnt + 1;
    if (ferr === 1'b1 && err_prev === 1'b1) err_long <= 1'b1;
  end

  typedef struct {
    string       name;
    logic [15:0] a;
    logic        iorq, rd, m1, tape;
    logic        oe;
    logic [7:0]  d;
  } vec_t;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [47:0] mkframe(input logic [39:0] k, input logic [7:0] j);
    return (FLEN == 48) ? {k, j} : {j, k};
  endfunction

  // Opens (or continues) a frame and clocks nbits out MSB first; CS stays low
  task automatic send_bits(input logic [47:0] v, input int nbits);
    kcs = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = FLEN - 1 - i;
      kdi = (idx >= 0) ? v[idx] : 1'b0;
      tick(4);
      kclk = 1'b1;
      tick(4);
      kclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic end_frame();
    kcs = 1'b1;
    tick(10);
  endtask

  task automatic do_read(input string nm, input logic [15:0] a, input logic exp_oe,
                         input logic [7:0] exp_d);
    @(negedge clk);
    addr = a; iorq = 1'b0; rd = 1'b0; m1 = 1'b1;
    @(posedge clk); #1;
    check({nm, ".oe"}, {7'h0, doe}, {7'h0, exp_oe});
    check({nm, ".d"}, dout, exp_d);
    @(negedge clk);
    addr = 16'hFFFF; iorq = 1'b1; rd = 1'b1;
  endtask

  localparam logic [39:0] PAT = 40'h80_0002_0041;

  initial begin
    vec_t vt[$];
    int   e0;
    bit   stable;

    rst_n = 1'b0; kclk = 1'b0; kcs = 1'b1; kdi = 1'b0;
    iorq = 1'b1; rd = 1'b1; m1 = 1'b1; tape = 1'b0; addr = 16'hFFFF;

    // rows: r0=01 r1=02 r3=04 r7=10; joystick byte 0A
    vt.push_back('{"fefe",  16'hFEFE, 0, 0, 1, 0, 1, 8'hBE});
    vt.push_back('{"fdfe",  16'hFDFE, 0, 0, 1, 0, 1, 8'hBD});
    vt.push_back('{"f7fe",  16'hF7FE, 0, 0, 1, 1, 1, 8'hFB});
    vt.push_back('{"7ffe",  16'h7FFE, 0, 0, 1, 0, 1, 8'hAF});
    vt.push_back('{"fcfe",  16'hFCFE, 0, 0, 1, 0, 1, 8'hBC});
    vt.push_back('{"00fe",  16'h00FE, 0, 0, 1, 0, 1, 8'hA8});
    vt.push_back('{"fffe",  16'hFFFE, 0, 0, 1, 0, 1, 8'hBF});
    vt.push_back('{"effe",  16'hEFFE, 0, 0, 1, 1, 1, 8'hFF});
    vt.push_back('{"a0hi",  16'hFEFF, 0, 0, 1, 0, 0, 8'hFF});
    vt.push_back('{"noiorq",16'hFEFE, 1, 0, 1, 0, 0, 8'hFF});
    vt.push_back('{"intack",16'h00FE, 0, 0, 0, 0, 0, 8'hFF});
    vt.push_back('{"write", 16'hFEFE, 0, 1, 1, 0, 0, 8'hFF});
    vt.push_back('{"p1f",   16'h001F, 0, 0, 1, 0, JOY, JOY ? 8'h0A : 8'hFF});
    vt.push_back('{"p1fm1", 16'h001F, 0, 0, 0, 0, 0, 8'hFF});

    tick(4);
    check("rst.d", dout, 8'hFF);
    check("rst.oe", {7'h0, doe}, 8'h00);
    check("rst.valid", {7'h0, kvalid}, 8'h00);
    check("rst.ferr", {7'h0, ferr}, 8'h00);
    rst_n = 1'b1;
    tick(4);

    do_read("t1.fefe", 16'hFEFE, 1'b1, 8'hBF);
    check("t1.valid", {7'h0, kvalid}, 8'h00);

    send_bits(mkframe(40'h1, 8'h00), FLEN);
    end_frame();
    check("t2.valid", {7'h0, kvalid}, 8'h01);
    check("t2.noerr", 8'(err_cnt), 8'd0);
    do_read("t2.fefe", 16'hFEFE, 1'b1, 8'hBE);
    do_read("t2.7ffe", 16'h7FFE, 1'b1, 8'hBF);

    send_bits(mkframe(PAT, 8'h0A), FLEN);
    end_frame();
    check("tab.noerr", 8'(err_cnt), 8'd0);
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      tape = vt[i].tape;
      tick(4);
      addr = vt[i].a; iorq = vt[i].iorq; rd = vt[i].rd; m1 = vt[i].m1;
      @(posedge clk); #1;
      check({vt[i].name, ".oe"}, {7'h0, doe}, {7'h0, vt[i].oe});
      check({vt[i].name, ".d"}, dout, vt[i].d);
      @(negedge clk);
      addr = 16'hFFFF; iorq = 1'b1; rd = 1'b1; m1 = 1'b1; tape = 1'b0;
    end
    tick(4);

    e0 = err_cnt;
    send_bits({48{1'b1}}, FLEN - 1);
    end_frame();
    check("t3.short.err", 8'(err_cnt - e0), 8'd1);
    do_read("t3.short.keep", 16'h00FE, 1'b1, 8'hA8);
    send_bits({48{1'b1}}, FLEN + 1);
    end_frame();
    check("t3.long.err", 8'(err_cnt - e0), 8'd2);
    do_read("t3.long.keep", 16'h00FE, 1'b1, 8'hA8);
    check("t3.pulse1", {7'h0, err_long}, 8'h00);

    // Commit arrives while an IN #00FE is held; data must not move until RD_n rises
    send_bits(mkframe(40'h0, 8'h00), FLEN);
    @(negedge clk);
    addr = 16'h00FE; iorq = 1'b0; rd = 1'b0; m1 = 1'b1;
    @(posedge clk); #1;
    check("t4.first", dout, 8'hA8);
    @(negedge clk);
    kcs = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dout !== 8'hA8 || doe !== 1'b1) stable = 1'b0;
    end
    check("t4.stable", {7'h0, stable}, 8'h01);
    @(negedge clk);
    addr = 16'hFFFF; iorq = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    check("t4.drop.oe", {7'h0, doe}, 8'h00);
    check("t4.drop.d", dout, 8'hFF);
    do_read("t4.new", 16'h00FE, 1'b1, 8'hBF);
    tick(6);

    // Reset in the middle of a frame
    e0 = err_cnt;
    send_bits({48{1'b1}}, 20);
    rst_n = 1'b0;
    tick(3);
    check("t5.rst.d", dout, 8'hFF);
    check("t5.rst.valid", {7'h0, kvalid}, 8'h00);
    rst_n = 1'b1;
    tick(4);
    send_bits({48{1'b1}}, FLEN - 20);
    end_frame();
    check("t5.noerr", 8'(err_cnt - e0), 8'd0);
    check("t5.valid0", {7'h0, kvalid}, 8'h00);
    check("t5.idle.d", dout, 8'hFF);
    send_bits(mkframe(40'h1, 8'h00), FLEN);
    end_frame();
    check("t5.valid1", {7'h0, kvalid}, 8'h01);
    do_read("t5.fefe", 16'hFEFE, 1'b1, 8'hBE);

    // 48-bit frame with joystick byte 10
    e0 = err_cnt;
    send_bits(mkframe(PAT, 8'h10), 48);
    end_frame();
    check("t6.err", 8'(err_cnt - e0), JOY ? 8'd0 : 8'd1);
    do_read("t6.p1f", 16'h001F, JOY, JOY ? 8'h10 : 8'hFF);
    do_read("t6.fefe", 16'hFEFE, 1'b1, JOY ? 8'hBE : 8'hBE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
